// File: rtl/issue_queue_int.sv
// ---------------------------------------------------------------------------
// issue_queue_int
//
// Integer issue queue placed directly after dispatch. It accepts up to
// DISPATCH_WIDTH micro-ops per cycle into the lowest-index free entries and
// tracks source-operand readiness through writeback-tag wakeup. Each cycle it
// offers up to ISSUE_WIDTH ready micro-ops to the integer execution ports,
// with the lowest-index ready entry going to port 0. Dispatch is backpressured
// whenever fewer than DISPATCH_WIDTH entries are free.
//
// micro_op_t is carried as a packed UOP_W-bit vector laid out as
//   { payload[PAYLOAD_W], rs2_preg[PREG_W], rs1_preg[PREG_W], valid }
// where valid is bit 0.
//
// Ports
//   clock          core clock; all state changes on the rising edge
//   reset_n        asynchronous active-low reset
//   flush          squash every entry at the next edge
//   uop_in         DISPATCH_WIDTH micro-ops from dispatch (slots need not be compacted)
//   rs1_ready_in   per-slot busy-table readiness of rs1 (1 = available or unused)
//   rs2_ready_in   per-slot busy-table readiness of rs2
//   dispatch_ready queue can accept a full dispatch group this cycle
//   wb_valid       per-port writeback wakeup tag valid
//   wb_preg        writeback wakeup tags
//   issue_uop      selected micro-ops per issue port; all-zero when idle
//   issue_ready    issue port accepts its micro-op at this edge
//   occupancy      number of valid entries
//
// Build option
//   IQ_FAST_WAKEUP_EN  when defined, same-cycle wakeup tags also count toward
//                      eligibility (0-cycle wakeup-to-issue). Otherwise only
//                      the stored ready bits are used (1-cycle wakeup-to-issue).
// ---------------------------------------------------------------------------
module issue_queue_int #(
  parameter int IQ_SIZE        = 16,
  parameter int DISPATCH_WIDTH = 4,
  parameter int ISSUE_WIDTH    = 2,
  parameter int WB_WIDTH       = 4,
  parameter int PREG_W         = 6,
  parameter int PAYLOAD_W      = 16,
  parameter int UOP_W          = PAYLOAD_W + 2*PREG_W + 1
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic                                    flush,
  input  logic [DISPATCH_WIDTH-1:0][UOP_W-1:0]    uop_in,
  input  logic [DISPATCH_WIDTH-1:0]               rs1_ready_in,
  input  logic [DISPATCH_WIDTH-1:0]               rs2_ready_in,
  output logic                                    dispatch_ready,
  input  logic [WB_WIDTH-1:0]                     wb_valid,
  input  logic [WB_WIDTH-1:0][PREG_W-1:0]         wb_preg,
  output logic [ISSUE_WIDTH-1:0][UOP_W-1:0]       issue_uop,
  input  logic [ISSUE_WIDTH-1:0]                  issue_ready,
  output logic [$clog2(IQ_SIZE):0]                occupancy
);

  localparam int IDX_W  = $clog2(IQ_SIZE);
  localparam int OCC_W  = IDX_W + 1;
  localparam int RS1_LO = 1;
  localparam int RS2_LO = 1 + PREG_W;

  function automatic logic tag_hit(input logic [PREG_W-1:0]               tag,
                                   input logic [WB_WIDTH-1:0]             vld,
                                   input logic [WB_WIDTH-1:0][PREG_W-1:0] preg);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_WIDTH; k++) hit = hit | (vld[k] & (preg[k] == tag));
    return hit;
  endfunction

  logic [IQ_SIZE-1:0][UOP_W-1:0]        ent_uop;
  logic [IQ_SIZE-1:0]                   ent_vld, ent_r1, ent_r2;
  logic [IQ_SIZE-1:0]                   wake1, wake2, elig;
  logic [ISSUE_WIDTH-1:0]               sel_vld, iss_fire;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]    sel_idx;
  logic [IQ_SIZE-1:0]                   sel_pool;
  logic [DISPATCH_WIDTH-1:0]            slot_vld, slot_ok;
  logic [DISPATCH_WIDTH-1:0][IDX_W-1:0] slot_idx;
  logic [IQ_SIZE-1:0]                   alloc_pool, ent_vld_nxt;
  logic [OCC_W-1:0]                     n_acc, n_iss;

  // Backpressure looks only at registered occupancy, never at same-cycle frees.
  assign dispatch_ready = (OCC_W'(IQ_SIZE) - occupancy) >= OCC_W'(DISPATCH_WIDTH);

  // ---- wakeup and eligibility (combinational from registered state) ----
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int e = 0; e < IQ_SIZE; e++) begin
      wake1[e] = tag_hit(ent_uop[e][RS1_LO +: PREG_W], wb_valid, wb_preg);
      wake2[e] = tag_hit(ent_uop[e][RS2_LO +: PREG_W], wb_valid, wb_preg);
    end
`ifdef IQ_FAST_WAKEUP_EN
    elig = ent_vld & (ent_r1 | wake1) & (ent_r2 | wake2);
`else
    elig = ent_vld & ent_r1 & ent_r2;
`endif
  end

  // ---- select: port k takes the k-th lowest eligible entry ----
  always_comb begin
    sel_pool  = elig;
    sel_vld   = '0;
    sel_idx   = '0;
    issue_uop = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      // Descending scan so the last hit written is the lowest index.
      for (int e = IQ_SIZE-1; e >= 0; e--) begin
        if (sel_pool[e]) begin
          sel_vld[k] = 1'b1;
          sel_idx[k] = IDX_W'(e);
        end
      end
      if (sel_vld[k]) begin
        sel_pool[sel_idx[k]] = 1'b0;
        issue_uop[k]         = ent_uop[sel_idx[k]];
      end
    end
    iss_fire = sel_vld & issue_ready;
  end

  // ---- allocation: slots in order take lowest free entries from the start-of-cycle free set ----
  always_comb begin
    alloc_pool  = ~ent_vld;
    slot_vld    = '0;
    slot_ok     = '0;
    slot_idx    = '0;
    n_acc       = '0;
    n_iss       = '0;
    ent_vld_nxt = ent_vld;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      slot_vld[i] = uop_in[i][0];
      if (slot_vld[i] && dispatch_ready) begin
        for (int e = IQ_SIZE-1; e >= 0; e--) begin
          if (alloc_pool[e]) begin
            slot_ok[i]  = 1'b1;
            slot_idx[i] = IDX_W'(e);
          end
        end
        if (slot_ok[i]) begin
          alloc_pool[slot_idx[i]]  = 1'b0;
          ent_vld_nxt[slot_idx[i]] = 1'b1;
          n_acc                    = n_acc + OCC_W'(1);
        end
      end
    end
    // An allocated entry was free at cycle start, so it can never also be issuing.
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (iss_fire[k]) begin
        ent_vld_nxt[sel_idx[k]] = 1'b0;
        n_iss                   = n_iss + OCC_W'(1);
      end
    end
  end

  // ---- control state: entry valid bits and occupancy ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_vld   <= '0;
      occupancy <= '0;
    end else if (flush) begin
      ent_vld   <= '0;
      occupancy <= '0;
    end else begin
      ent_vld   <= ent_vld_nxt;
      occupancy <= occupancy + n_acc - n_iss;
    end
  end

  // ---- entry payload and ready bits (qualified by ent_vld, so no reset) ----
  always_ff @(posedge clock) begin
    ent_r1 <= ent_r1 | wake1;
    ent_r2 <= ent_r2 | wake2;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (slot_ok[i]) begin
        ent_uop[slot_idx[i]] <= uop_in[i];
        // Write-time wakeup catches a broadcast that coincides with dispatch.
        ent_r1[slot_idx[i]]  <= rs1_ready_in[i] |
                                tag_hit(uop_in[i][RS1_LO +: PREG_W], wb_valid, wb_preg);
        ent_r2[slot_idx[i]]  <= rs2_ready_in[i] |
                                tag_hit(uop_in[i][RS2_LO +: PREG_W], wb_valid, wb_preg);
      end
    end
  end

`ifndef SYNTHESIS
  // Dispatch must not present valid micro-ops while backpressured; they are dropped.
  a_no_dispatch_when_full: assert property (@(posedge clock) disable iff (!reset_n)
    (!dispatch_ready |-> (slot_vld == '0)));
`endif

endmodule

// File: tb/tb_issue_queue_int.sv
module tb_issue_queue_int;
  localparam int DW  = 4;
  localparam int IW  = 2;
  localparam int WBW = 4;
  localparam int PW  = 6;
  localparam int PLW = 16;
  localparam int UW  = PLW + 2*PW + 1;
`ifdef IQ_FAST_WAKEUP_EN
  localparam int WD = 0;
`else
  localparam int WD = 1;
`endif

  logic                     clock = 1'b0;
  logic                     reset_n;
  logic                     flush;
  logic [DW-1:0][UW-1:0]    uop_in;
  logic [DW-1:0]            rs1_ready_in, rs2_ready_in;
  logic                     dispatch_ready;
  logic [WBW-1:0]           wb_valid;
  logic [WBW-1:0][PW-1:0]   wb_preg;
  logic [IW-1:0][UW-1:0]    issue_uop;
  logic [IW-1:0]            issue_ready;
  logic [4:0]               occupancy;

  issue_queue_int dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .uop_in(uop_in), .rs1_ready_in(rs1_ready_in), .rs2_ready_in(rs2_ready_in),
    .dispatch_ready(dispatch_ready), .wb_valid(wb_valid), .wb_preg(wb_preg),
    .issue_uop(issue_uop), .issue_ready(issue_ready), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int             cyc;
    int             port;
    logic [UW-1:0]  uop;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [UW-1:0] mk(input int pl, input int rs2, input int rs1);
    return {PLW'(pl), PW'(rs2), PW'(rs1), 1'b1};
  endfunction

  task automatic expect_issue(input int c, input int p, input logic [UW-1:0] u);
    exp_t e;
    e.cyc = c; e.port = p; e.uop = u;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic put(input int s, input logic [UW-1:0] u, input logic r1, input logic r2);
    uop_in[s]       = u;
    rs1_ready_in[s] = r1;
    rs2_ready_in[s] = r2;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    uop_in = '0; rs1_ready_in = '0; rs2_ready_in = '0;
    wb_valid = '0; wb_preg = '0; flush = 1'b0;
  endtask

  // Monitor: every presented issue must match the next scoreboard entry.
  always @(negedge clock) begin : mon
    exp_t e;
    if (reset_n && !flush) begin
      for (int k = 0; k < IW; k++) begin
        if (issue_uop[k][0]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_p%0d: got uop %h in cycle %0d, want no issue", k, issue_uop[k], cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.port != k || e.uop != issue_uop[k]) begin
              errors++;
              $display("FAIL issue_p%0d: got uop %h cycle %0d, want uop %h cycle %0d port %0d",
                       k, issue_uop[k], cyc, e.uop, e.cyc, e.port);
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0; flush = 1'b0; uop_in = '0; rs1_ready_in = '0; rs2_ready_in = '0;
    wb_valid = '0; wb_preg = '0; issue_ready = 2'b11;

    @(negedge clock);
    chk("reset_occ", int'(occupancy), 0);
    chk("reset_drdy", int'(dispatch_ready), 1);
    chk("reset_idle", int'(issue_uop != '0), 0);
    step();
    reset_n = 1'b1;
    step();

    // 4 ready uops: two issue at N+1, two at N+2
    n = cyc;
    for (int s = 0; s < 4; s++) put(s, mk(16'h100 + s, s + 1, s + 1), 1'b1, 1'b1);
    expect_issue(n + 1, 0, mk(16'h100, 1, 1));
    expect_issue(n + 1, 1, mk(16'h101, 2, 2));
    expect_issue(n + 2, 0, mk(16'h102, 3, 3));
    expect_issue(n + 2, 1, mk(16'h103, 4, 4));
    step();
    chk("t1_occ_4", int'(occupancy), 4);
    chk("t1_drdy", int'(dispatch_ready), 1);
    step();
    chk("t1_occ_2", int'(occupancy), 2);
    step();
    chk("t1_occ_0", int'(occupancy), 0);

    // rs1=7 not ready, woken at N+3
    n = cyc;
    put(0, mk(16'h200, 10, 7), 1'b0, 1'b1);
    expect_issue(n + 3 + WD, 0, mk(16'h200, 10, 7));
    step();
    chk("t2_occ_1", int'(occupancy), 1);
    step();
    step();
    wb_valid[0] = 1'b1; wb_preg[0] = 6'd7;
    step();
    step();
    chk("t2_occ_0", int'(occupancy), 0);

    // rs2=9 woken in the dispatch cycle, uncompacted slot 2
    n = cyc;
    put(2, mk(16'h300, 9, 11), 1'b1, 1'b0);
    wb_valid[2] = 1'b1; wb_preg[2] = 6'd9;
    expect_issue(n + 1, 0, mk(16'h300, 9, 11));
    step();
    chk("t3_occ_1", int'(occupancy), 1);
    step();
    chk("t3_occ_0", int'(occupancy), 0);

    // Fill to 13 blocked entries (rs1 tags 20..32 in entries 0..12)
    for (int g = 0; g < 3; g++) begin
      for (int s = 0; s < 4; s++) put(s, mk(16'h400 + g*4 + s, 50, 20 + g*4 + s), 1'b0, 1'b1);
      step();
      chk("t4_occ_fill", int'(occupancy), (g + 1) * 4);
      chk("t4_drdy_fill", int'(dispatch_ready), 1);
    end
    put(0, mk(16'h40C, 50, 32), 1'b0, 1'b1);
    step();
    chk("t4_occ_13", int'(occupancy), 13);
    chk("t4_drdy_full", int'(dispatch_ready), 0);
    n = cyc;
    wb_valid[1] = 1'b1; wb_preg[1] = 6'd25;
    expect_issue(n + WD, 0, mk(16'h405, 50, 25));
    step();
    chk("t4_occ_q1", int'(occupancy), 12 + WD);
    chk("t4_drdy_q1", int'(dispatch_ready), 1 - WD);
    step();
    chk("t4_occ_q2", int'(occupancy), 12);
    chk("t4_drdy_q2", int'(dispatch_ready), 1);

    // Two eligible, only port 0 accepts: port 1 entry moves to port 0 next cycle
    n = cyc;
    issue_ready = 2'b01;
    wb_valid = 4'b0011; wb_preg[0] = 6'd20; wb_preg[1] = 6'd21;
    expect_issue(n + WD,     0, mk(16'h400, 50, 20));
    expect_issue(n + WD,     1, mk(16'h401, 50, 21));
    expect_issue(n + WD + 1, 0, mk(16'h401, 50, 21));
    step();
    step();
    issue_ready = 2'b11;
    step();
    chk("t5_occ_10", int'(occupancy), 10);

    // Flush coincident with a 2-uop dispatch
    flush = 1'b1;
    put(0, mk(16'h600, 1, 1), 1'b1, 1'b1);
    put(3, mk(16'h601, 2, 2), 1'b1, 1'b1);
    step();
    chk("t6_occ_flush", int'(occupancy), 0);
    chk("t6_drdy_flush", int'(dispatch_ready), 1);
    wb_valid = 4'hF;
    wb_preg[0] = 6'd22; wb_preg[1] = 6'd23; wb_preg[2] = 6'd24; wb_preg[3] = 6'd26;
    step();
    step();
    step();
    chk("t6_occ_after", int'(occupancy), 0);
    chk("t6_idle", int'(issue_uop != '0), 0);

    // Asynchronous reset mid-operation discards a resident entry
    put(0, mk(16'h700, 3, 40), 1'b0, 1'b1);
    step();
    chk("t7_occ_1", int'(occupancy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_occ_rst", int'(occupancy), 0);
    chk("t7_drdy_rst", int'(dispatch_ready), 1);
    step();
    reset_n = 1'b1;
    wb_valid[0] = 1'b1; wb_preg[0] = 6'd40;
    step();
    step();
    chk("t7_occ_after", int'(occupancy), 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
